// File: rtl/step_tick_gen.sv
// -----------------------------------------------------------------------------
// step_tick_gen
// Programmable tick-pulse source. After an accepted start it emits one-cycle
// tick pulses every p_eff cycles, where p_eff = max(period, MIN_PERIOD). A
// non-zero num_ticks gives a finite burst that ends with a one-cycle done
// pulse; num_ticks = 0 runs continuously until stop.
//
// Optional feature macro: STEP_TICK_DIR_EN (adds dir / dir_out).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   begin generation (honoured only in IDLE)
//   stop        in   abort generation (honoured only in RUN, beats a due tick)
//   period      in   cycles between ticks, clamped below at MIN_PERIOD
//   num_ticks   in   burst length, 0 = continuous
//   tick        out  registered one-cycle step pulse
//   busy        out  high while the FSM is not in IDLE
//   done        out  registered one-cycle pulse at burst completion
//   ticks_sent  out  ticks issued since the last accepted start
//   dir         in   (STEP_TICK_DIR_EN only) requested direction
//   dir_out     out  (STEP_TICK_DIR_EN only) direction, stable around ticks
// -----------------------------------------------------------------------------
module step_tick_gen #(
   parameter int PERIOD_W   = 16,
   parameter int COUNT_W    = 16,
   parameter int MIN_PERIOD = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [PERIOD_W-1:0] period,
   input  logic [COUNT_W-1:0]  num_ticks,
   output logic                tick,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  ticks_sent
`ifdef STEP_TICK_DIR_EN
   ,
   input  logic                dir,
   output logic                dir_out
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] PH_ONE  = PERIOD_W'(1);
   localparam logic [COUNT_W-1:0]  CNT_ONE = COUNT_W'(1);

   state_t                state, state_nxt;
   logic [PERIOD_W-1:0]   phase, phase_nxt;
   logic [PERIOD_W-1:0]   p_lat, p_nxt;
   logic [COUNT_W-1:0]    n_lat, n_nxt;
   logic [COUNT_W-1:0]    ts_nxt;
   logic [COUNT_W-1:0]    ts_inc;
   logic [PERIOD_W-1:0]   p_eff;
   logic                  tick_nxt;
   logic                  done_nxt;
   logic                  busy_nxt;

   // Clamp the requested period to the minimum (full-width unsigned compare).
   always_comb begin
      p_eff = period;
      if (period < MIN_P) begin
         p_eff = MIN_P;
      end else begin
         p_eff = period;
      end
   end

   assign ts_inc = ticks_sent + CNT_ONE;

   // Next-state and next-output logic for the IDLE/RUN/FINISH sequencer.
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      p_nxt     = p_lat;
      n_nxt     = n_lat;
      ts_nxt    = ticks_sent;
      tick_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            // stop is deliberately ignored here, so start+stop still starts
            if (start) begin
               p_nxt     = p_eff;
               n_nxt     = num_ticks;
               ts_nxt    = {COUNT_W{1'b0}};
               phase_nxt = PH_ONE;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (phase == p_lat) begin
               tick_nxt  = 1'b1;
               phase_nxt = PH_ONE;
               ts_nxt    = ts_inc;
               // new period only takes effect at an interval boundary
               p_nxt     = p_eff;
               if ((n_lat != {COUNT_W{1'b0}}) && (ts_inc == n_lat)) begin
                  state_nxt = FINISH;
               end else begin
                  state_nxt = RUN;
               end
            end else begin
               phase_nxt = phase + PH_ONE;
            end
         end
         FINISH: begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (state_nxt != IDLE) begin
         busy_nxt = 1'b1;
      end else begin
         busy_nxt = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= {PERIOD_W{1'b0}};
         p_lat      <= {PERIOD_W{1'b0}};
         n_lat      <= {COUNT_W{1'b0}};
         ticks_sent <= {COUNT_W{1'b0}};
         tick       <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         p_lat      <= p_nxt;
         n_lat      <= n_nxt;
         ticks_sent <= ts_nxt;
         tick       <= tick_nxt;
         done       <= done_nxt;
         busy       <= busy_nxt;
      end
   end

`ifdef STEP_TICK_DIR_EN
   // Direction is resampled only at start and as tick falls, so it is never
   // changing while a tick is high or in the cycle just before it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_out <= 1'b0;
      end else if ((state == IDLE) && start) begin
         dir_out <= dir;
      end else if (tick && !tick_nxt) begin
         dir_out <= dir;
      end else begin
         dir_out <= dir_out;
      end
   end
`else
   // Without the direction option there is no direction state at all.
`endif

endmodule
